// File: rtl/pwm_capture.sv
// pwm_capture: recovers one signed sample per 1024-cycle frame from a PWM stream.
// The duty count H of each frame is mapped back to D-512 (D = H-1, clamped at 0),
// which inverts the transmit-side PWM DAC. Samples leave on a valid/ready port
// backed by a single output register.
module pwm_capture #(
  parameter int FRAME_BITS = 10,
  parameter int OUT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             locked,
  output logic             overrun,
  output logic             resync,
  input  logic             flag_clr
);

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [FRAME_BITS-1:0] FRAME_ZERO = {FRAME_BITS{1'b0}};
  localparam logic [FRAME_BITS-1:0] FRAME_ONE  = {{(FRAME_BITS-1){1'b0}}, 1'b1};
  localparam logic [FRAME_BITS-1:0] FRAME_LAST = {FRAME_BITS{1'b1}};
  localparam logic [FRAME_BITS:0]   HIGH_ZERO  = {(FRAME_BITS+1){1'b0}};
  localparam logic [FRAME_BITS:0]   HIGH_ONE   = {{FRAME_BITS{1'b0}}, 1'b1};

  // synchronizer and edge detect
  logic sync_meta_r;
  logic s_r;
  logic s_d_r;
  logic rise_s;

  // frame measurement
  state_t                state_r;
  state_t                state_nxt_s;
  logic [FRAME_BITS-1:0] frame_cnt_r;
  logic [FRAME_BITS-1:0] frame_cnt_nxt_s;
  logic [FRAME_BITS:0]   high_cnt_r;
  logic [FRAME_BITS:0]   high_cnt_nxt_s;
  logic [FRAME_BITS:0]   h_sum_s;
  logic [FRAME_BITS-1:0] duty_s;
  logic [FRAME_BITS-1:0] offset_s;
  logic                  launch_s;
  logic [OUT_W-1:0]      launch_val_s;
  logic                  resync_set_s;
  logic                  overrun_set_s;

  // output registers
  logic [OUT_W-1:0] sample_out_r;
  logic             sample_valid_r;
  logic             locked_r;
  logic             overrun_r;
  logic             resync_r;

  // Two-flop synchronizer for the asynchronous PWM pin plus one delay stage for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_r <= 1'b0;
      s_r         <= 1'b0;
      s_d_r       <= 1'b0;
    end else begin
      sync_meta_r <= pwm_in;
      s_r         <= sync_meta_r;
      s_d_r       <= s_r;
    end
  end

  assign rise_s = s_r & ~s_d_r;

  // Duty decode: H counts high cycles including the current one; an all-low frame saturates at D=0.
  always_comb begin
    h_sum_s = high_cnt_r + {{FRAME_BITS{1'b0}}, s_r};
    if (h_sum_s == HIGH_ZERO) begin
      duty_s = FRAME_ZERO;
    end else begin
      // H=1024 wraps its low bits to 0, so subtracting one lands on 1023 as required.
      duty_s = h_sum_s[FRAME_BITS-1:0] - FRAME_ONE;
    end
    offset_s     = {~duty_s[FRAME_BITS-1], duty_s[FRAME_BITS-2:0]};
    launch_val_s = {{(OUT_W-FRAME_BITS){offset_s[FRAME_BITS-1]}}, offset_s};
  end

  // Next-state logic: SEEK waits for the first edge, MEASURE tracks frames and realigns on stray edges.
  always_comb begin
    state_nxt_s     = state_r;
    frame_cnt_nxt_s = frame_cnt_r;
    high_cnt_nxt_s  = high_cnt_r;
    launch_s        = 1'b0;
    resync_set_s    = 1'b0;
    case (state_r)
      SEEK: begin
        if (rise_s) begin
          // The edge cycle itself is frame cycle 0 and is high.
          state_nxt_s     = MEASURE;
          frame_cnt_nxt_s = FRAME_ONE;
          high_cnt_nxt_s  = HIGH_ONE;
        end else begin
          state_nxt_s = SEEK;
        end
      end
      MEASURE: begin
        state_nxt_s     = MEASURE;
        frame_cnt_nxt_s = frame_cnt_r + FRAME_ONE;
        if (rise_s && (frame_cnt_r != FRAME_ZERO)) begin
          // Edge in the middle of a frame: drop the partial frame and restart on this edge.
          frame_cnt_nxt_s = FRAME_ONE;
          high_cnt_nxt_s  = HIGH_ONE;
          resync_set_s    = 1'b1;
        end else if (frame_cnt_r == FRAME_ZERO) begin
          high_cnt_nxt_s = {{FRAME_BITS{1'b0}}, s_r};
        end else if (frame_cnt_r == FRAME_LAST) begin
          launch_s       = 1'b1;
          high_cnt_nxt_s = h_sum_s;
        end else begin
          high_cnt_nxt_s = h_sum_s;
        end
      end
      default: begin
        state_nxt_s     = SEEK;
        frame_cnt_nxt_s = FRAME_ZERO;
        high_cnt_nxt_s  = HIGH_ZERO;
      end
    endcase
  end

  // State and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SEEK;
      frame_cnt_r <= FRAME_ZERO;
      high_cnt_r  <= HIGH_ZERO;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      high_cnt_r  <= high_cnt_nxt_s;
      locked_r    <= (state_nxt_s == MEASURE);
    end
  end

  assign overrun_set_s = launch_s & sample_valid_r & ~sample_ready;

  // Single-entry output holding register; a new launch always replaces the held sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out_r   <= {OUT_W{1'b0}};
      sample_valid_r <= 1'b0;
    end else if (launch_s) begin
      sample_out_r   <= launch_val_s;
      sample_valid_r <= 1'b1;
    end else if (sample_valid_r && sample_ready) begin
      sample_valid_r <= 1'b0;
    end else begin
      sample_valid_r <= sample_valid_r;
    end
  end

  // Sticky status flags; a set in the same cycle as a clear takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
      resync_r  <= 1'b0;
    end else begin
      overrun_r <= overrun_set_s | (overrun_r & ~flag_clr);
      resync_r  <= resync_set_s  | (resync_r  & ~flag_clr);
    end
  end

  assign sample_out   = sample_out_r;
  assign sample_valid = sample_valid_r;
  assign locked       = locked_r;
  assign overrun      = overrun_r;
  assign resync       = resync_r;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM DAC-style and random streams into pwm_capture.
// A frame-level reference model pushes expected samples into a queue; a separate
// monitor pops them whenever the DUT hands over a sample and compares.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic        sample_ready = 1'b1;
  logic        flag_clr = 1'b0;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        locked;
  logic        overrun;
  logic        resync;

  int tests = 0;
  int fails = 0;
  int n_consumed = 0;

  // stimulus control
  int rdy_mode = 0;   // 0: always ready, 1: random ready, 2: never ready
  bit clr_req = 1'b0;

  // reference model state
  int      exp_q[$];
  bit      frame_bits[$];
  bit      m1, ms, msd;
  bit      mlock, mvalid, movr, mres;
  longint  t_now, t_start;

  always #5 clk = ~clk;

  pwm_capture #(.FRAME_BITS(10), .OUT_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .locked       (locked),
    .overrun      (overrun),
    .resync       (resync),
    .flag_clr     (flag_clr)
  );

  function automatic void check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 20) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    frame_bits.delete();
    m1 = 1'b0; ms = 1'b0; msd = 1'b0;
    mlock = 1'b0; mvalid = 1'b0; movr = 1'b0; mres = 1'b0;
    t_now = 0; t_start = 0;
  endfunction

  // One clock of the reference: frames are windows of 1024 synchronized input bits,
  // anchored at the first edge and re-anchored at any edge not on a frame boundary.
  function automatic void model_step();
    bit cur_s, rise, launch, cons;
    int h, val;
    cur_s  = ms;
    rise   = ms && !msd;
    launch = 1'b0;
    val    = 0;
    cons   = mvalid && sample_ready;
    if (flag_clr) begin
      movr = 1'b0;
      mres = 1'b0;
    end
    if (!mlock) begin
      if (rise) begin
        mlock = 1'b1;
        t_start = t_now;
        frame_bits.delete();
        frame_bits.push_back(1'b1);
      end
    end else if (rise && (((t_now - t_start) % 1024) != 0)) begin
      mres = 1'b1;
      t_start = t_now;
      frame_bits.delete();
      frame_bits.push_back(1'b1);
    end else begin
      if (((t_now - t_start) % 1024) == 0) frame_bits.delete();
      frame_bits.push_back(cur_s);
      if (frame_bits.size() == 1024) begin
        h = 0;
        foreach (frame_bits[i]) h += int'(frame_bits[i]);
        val = (h == 0) ? -512 : h - 513;
        launch = 1'b1;
      end
    end
    if (cons) mvalid = 1'b0;
    if (launch) begin
      if (mvalid) begin
        movr = 1'b1;
        exp_q[exp_q.size()-1] = val;
      end else begin
        exp_q.push_back(val);
      end
      mvalid = 1'b1;
    end
    msd = ms;
    ms  = m1;
    m1  = pwm_in;
    t_now++;
  endfunction

  // Reference model process, tracking the same clock and asynchronous reset as the DUT.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else model_step();
    end
  end

  // Monitor: status flags every cycle; pop and compare whenever a sample is handed over.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid", int'(sample_valid), int'(mvalid));
        check("locked", int'(locked), int'(mlock));
        check("overrun", int'(overrun), int'(movr));
        check("resync", int'(resync), int'(mres));
        if (sample_valid && sample_ready) begin
          n_consumed++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sample_unexpected: got %0d, expected no sample (t=%0t)",
                     $signed(sample_out), $time);
          end else begin
            tests--;
            e = exp_q.pop_front();
            check("sample", $signed(sample_out), e);
          end
        end
      end
    end
  end

  task automatic tick(input bit p);
    @(posedge clk);
    #1;
    pwm_in = p;
    if (rdy_mode == 0) sample_ready = 1'b1;
    else if (rdy_mode == 1) sample_ready = ($urandom_range(0, 3) != 0);
    else sample_ready = 1'b0;
    flag_clr = clr_req;
    clr_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // PWM DAC: each 1024-cycle period is high for v+513 cycles starting at the period start.
  task automatic dac(input int v, input int n_frames, input int cycles);
    for (int f = 0; f < n_frames; f++)
      for (int c = 0; c < cycles; c++) tick(c < v + 513);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample_out"}, int'(sample_out), 0);
    check({tag, "_valid"}, int'(sample_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_resync"}, int'(resync), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // low input never locks
    idle(60);
    check("no_lock_low", int'(locked), 0);

    // loopback sweep
    dac(0, 3, 1024);
    dac(-512, 2, 1024);
    dac(-1, 2, 1024);
    dac(1, 2, 1024);
    dac(511, 3, 1024);
    check("locked_const_high", int'(locked), 1);
    dac(0, 1, 1024);
    rdy_mode = 1;
    for (int k = 0; k < 5; k++) dac(int'($urandom_range(0, 1023)) - 512, 1, 1024);

    // low after lock: saturated -512 every frame, no realignment
    clr_req = 1'b1;
    tick(1'b0);
    idle(3 * 1024 + 20);
    check("low_after_lock_resync", int'(resync), 0);
    check("low_after_lock_locked", int'(locked), 1);

    // backpressure
    rdy_mode = 0;
    dac(100, 1, 1024);
    rdy_mode = 2;
    dac(-200, 2, 1024);
    dac(300, 1, 1024);
    check("bp_overrun", int'(overrun), 1);
    clr_req = 1'b1;
    tick(1'b0);
    tick(1'b0);
    check("bp_overrun_clr", int'(overrun), 0);
    check("bp_still_held", int'(sample_valid), 1);
    rdy_mode = 0;
    tick(1'b0);
    tick(1'b0);
    check("bp_valid_drop", int'(sample_valid), 0);

    // phase jump of 300+1 cycles
    dac(50, 2, 1024);
    clr_req = 1'b1;
    tick(1'b0);
    idle(300);
    dac(50, 3, 1024);
    check("phase_jump_resync", int'(resync), 1);

    // random stream with arbitrary run lengths
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) begin
      int len;
      bit b;
      len = $urandom_range(1, 900);
      b = 1'(($urandom_range(0, 1)));
      for (int i = 0; i < len; i++) tick(b);
    end

    // mid-frame reset
    rdy_mode = 0;
    idle(10);
    dac(200, 1, 502);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pwm_in = 1'b0;
    idle(30);
    check("relock_wait", int'(locked), 0);
    dac(-100, 3, 1024);
    check("relock_locked", int'(locked), 1);
    idle(10);

    check("samples_seen_enough", int'(n_consumed >= 25), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
